// File: rtl/keyboard_renderer.sv
// keyboard_renderer: draws key columns and a mode indicator to a pixel plotter,
// one pixel per cycle, redrawing whenever the shown keys or mode change.
module keyboard_renderer #(
  parameter int NUM_KEYS = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int KEY_W    = SCREEN_W / NUM_KEYS,
  parameter int IND_SIZE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] playback_keys,
  input  logic [1:0]          mode,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done
);
  localparam int CW = $clog2(NUM_KEYS);
  localparam int PW = $clog2(KEY_W + 1);
  typedef enum logic [1:0] {INIT, IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] x_cnt;
  logic [6:0] y_cnt;
  logic [CW-1:0] col;
  logic [PW-1:0] pos;
  logic [NUM_KEYS-1:0] shown_keys, sel_keys;
  logic [1:0] shown_mode, mode_n;
  logic last_x, last_y, key_edge, last_col, divider, remainder, ind;
  logic [2:0] pix;
  always_comb begin
    mode_n    = mode == 2'b11 ? 2'b00 : mode;
    sel_keys  = mode_n == 2'b10 ? playback_keys : keys;
    last_x    = x_cnt == 8'(SCREEN_W - 1);
    last_y    = y_cnt == 7'(SCREEN_H - 1);
    key_edge  = pos == PW'(KEY_W - 1);
    last_col  = col == CW'(NUM_KEYS - 1);
    divider   = key_edge && !last_col;
    remainder = x_cnt >= 8'(NUM_KEYS * KEY_W);
    ind       = x_cnt < 8'(IND_SIZE) && y_cnt < 7'(IND_SIZE);
    pix       = ind && shown_mode == 2'b01 ? 3'b100 :
                ind && shown_mode == 2'b10 ? 3'b010 :
                divider || remainder       ? 3'b000 :
                shown_keys[col]            ? 3'b001 : 3'b111;
    state_n   = state == INIT ? SCAN :
                state == IDLE ? ((sel_keys != shown_keys || mode_n != shown_mode) ? SCAN : IDLE) :
                state == SCAN ? ((last_x && last_y) ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= INIT;
      x_cnt      <= '0;
      y_cnt      <= '0;
      col        <= '0;
      pos        <= '0;
      shown_keys <= '0;
      shown_mode <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_cnt;
      y          <= y_cnt;
      plot       <= state == SCAN;
      colour     <= state == SCAN ? pix : 3'b000;
      busy       <= state_n != IDLE;
      frame_done <= state_n == DONE;
      if (state_n == SCAN && state != SCAN) begin
        shown_keys <= sel_keys;
        shown_mode <= mode_n;
      end
      if (state == SCAN) begin
        x_cnt <= last_x ? 8'd0 : x_cnt + 8'd1;
        pos   <= (last_x || key_edge) ? '0 : pos + PW'(1);
        col   <= last_x ? '0 : (key_edge && !last_col) ? col + CW'(1) : col;
        if (last_x) y_cnt <= last_y ? 7'd0 : y_cnt + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_keyboard_renderer.sv
// tb_keyboard_renderer: randomized and directed frames checked pixel by pixel
// against a column/divider arithmetic model of the keyboard picture.
module tb_keyboard_renderer;
  localparam int W = 160, H = 30, NK = 4, KW = 40, IND = 4;
  logic clock = 0, reset = 0;
  logic [3:0] keys = 0, playback_keys = 0;
  logic [1:0] mode = 0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, frame_done;
  int n_checks = 0, n_pass = 0;
  int pix_idx, bad, segs, fd_cnt, rst_plot, busy_cnt, ex, ey;
  logic prev_plot = 0;
  logic [2:0] row0 [W];
  logic [3:0] exp_keys = 0;
  logic [1:0] exp_mode = 0;

  keyboard_renderer #(.NUM_KEYS(NK), .SCREEN_W(W), .SCREEN_H(H), .KEY_W(KW), .IND_SIZE(IND)) dut (
    .clock(clock), .reset(reset), .keys(keys), .playback_keys(playback_keys), .mode(mode),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  function automatic logic [1:0] norm(input logic [1:0] m);
    return m == 2'b11 ? 2'b00 : m;
  endfunction

  function automatic logic [3:0] sel(input logic [3:0] k, input logic [3:0] pb, input logic [1:0] m);
    return norm(m) == 2'b10 ? pb : k;
  endfunction

  function automatic logic [2:0] ref_colour(input int px, input int py, input logic [3:0] k, input logic [1:0] m);
    if (px < IND && py < IND && m == 2'b01) return 3'b100;
    if (px < IND && py < IND && m == 2'b10) return 3'b010;
    if (px >= NK * KW || (px % KW == KW - 1 && px / KW < NK - 1)) return 3'b000;
    return k[px / KW] ? 3'b001 : 3'b111;
  endfunction

  always @(posedge clock) begin
    #1;
    if (plot) begin
      ex = pix_idx % W;
      ey = pix_idx / W;
      if ({x, y, colour} !== {8'(ex), 7'(ey), ref_colour(ex, ey, exp_keys, exp_mode)}) begin
        if (bad < 3) $display("  bad pixel %0d: x=%0d y=%0d c=%b", pix_idx, x, y, colour);
        bad++;
      end
      if (ey == 0) row0[ex] = colour;
      if (!prev_plot) segs++;
      pix_idx++;
    end
    if (!reset && plot) rst_plot++;
    if (frame_done) fd_cnt++;
    if (busy) busy_cnt++;
    prev_plot = plot;
  end

  task automatic clear_stats();
    pix_idx = 0; bad = 0; segs = 0; fd_cnt = 0; rst_plot = 0; busy_cnt = 0;
  endtask

  task automatic drive(input logic [3:0] k, input logic [3:0] pb, input logic [1:0] m);
    keys = k; playback_keys = pb; mode = m;
    exp_keys = sel(k, pb, m); exp_mode = norm(m);
  endtask

  task automatic end_frame(input string tag);
    int i;
    for (i = 0; i < W * H + 50 && fd_cnt == 0; i++) @(negedge clock);
    check({tag, "_timeout"}, fd_cnt > 0, 1);
    @(negedge clock);
    check({tag, "_pixels"}, bad, 0);
    check({tag, "_plots"}, pix_idx, W * H);
    check({tag, "_runs"}, segs, 1);
    check({tag, "_done"}, fd_cnt, 1);
    check({tag, "_busy_low"}, busy, 0);
    clear_stats();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k, pb;
    logic [1:0] m;
    clear_stats();
    drive(4'b0000, 4'b0000, 2'b00);
    repeat (3) @(negedge clock);
    check("reset_out", {plot, busy, frame_done, x, y, colour}, 0);
    reset = 1;
    end_frame("first");
    check("first_x39", row0[39], 3'b000);
    check("first_x79", row0[79], 3'b000);
    check("first_x119", row0[119], 3'b000);
    check("first_x0", row0[0], 3'b111);
    check("first_x159", row0[159], 3'b111);
    repeat (50) @(negedge clock);
    check("idle_plots", pix_idx, 0);
    check("idle_busy", busy_cnt, 0);
    drive(4'b0101, 4'b0000, 2'b00);
    end_frame("k0101");
    check("k0101_x0", row0[0], 3'b001);
    check("k0101_x40", row0[40], 3'b111);
    check("k0101_x80", row0[80], 3'b001);
    check("k0101_x118", row0[118], 3'b001);
    check("k0101_x120", row0[120], 3'b111);
    drive(4'b0000, 4'b0000, 2'b01);
    end_frame("rec");
    check("rec_x0", row0[0], 3'b100);
    check("rec_x3", row0[3], 3'b100);
    check("rec_x4", row0[4], 3'b111);
    check("rec_x39", row0[39], 3'b000);
    drive(4'b0001, 4'b1000, 2'b10);
    end_frame("play");
    check("play_x0", row0[0], 3'b010);
    check("play_x10", row0[10], 3'b111);
    check("play_x120", row0[120], 3'b001);
    check("play_x159", row0[159], 3'b001);
    drive(4'b0000, 4'b0000, 2'b00);
    for (int i = 0; i < W * H && pix_idx < 2000; i++) @(negedge clock);
    check("toggle_reach", pix_idx >= 2000, 1);
    keys = 4'b0010;
    end_frame("toggle1");
    exp_keys = 4'b0010;
    end_frame("toggle2");
    check("toggle2_x40", row0[40], 3'b001);
    check("toggle2_x0", row0[0], 3'b111);
    drive(4'b0011, 4'b0000, 2'b00);
    for (int i = 0; i < W * H && pix_idx < 3000; i++) @(negedge clock);
    check("rst_reach", pix_idx >= 3000, 1);
    reset = 0;
    repeat (4) @(negedge clock);
    check("midrst_out", {plot, busy, frame_done, x, y, colour}, 0);
    check("midrst_plots", rst_plot, 0);
    clear_stats();
    reset = 1;
    end_frame("restart");
    for (int r = 0; r < 4; r++) begin
      do begin
        k = 4'($urandom_range(0, 15));
        pb = 4'($urandom_range(0, 15));
        m = 2'($urandom_range(0, 3));
      end while (sel(k, pb, m) == exp_keys && norm(m) == exp_mode);
      drive(k, pb, m);
      end_frame($sformatf("rand%0d", r));
    end
    repeat (30) @(negedge clock);
    check("final_idle_plots", pix_idx, 0);
    check("final_idle_busy", busy_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
